ascii_mux_display: RTL and testbench
====================================

# ascii_mux_display

Parametrised multi-digit, time-multiplexed 7-segment driver with per-digit ASCII decode, a writable message buffer and optional horizontal scrolling. It succeeds the single-digit ASCII common-cathode driver. It sits between application logic, which writes characters, and the board's segment/digit-select pins. Digit polarity is selectable for common-cathode or common-anode boards.

## Interface
- DIGITS, 4: number of physical digits, 1..8.
- MSG_LEN, 16: message buffer depth in characters; must be ≥ DIGITS.
- TICK_DIV, 12500: clocks per digit slot (50 MHz / 12500 = 4 kHz slot, 1 kHz frame at 4 digits).
- BLANK_CYCLES, 50: ghost-suppression clocks at the start of each slot; must be < TICK_DIV.
- SCROLL_FRAMES, 250: frames per scroll step.
- COMMON_ANODE, 0: 0 means active-high segments and selects; 1 inverts Segments, dp and Digit_sel.
- clk50MHz  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write strobe, one character per clock.
- wr_addr  input  $clog2(MSG_LEN)  buffer index.
- wr_data  input  8  ASCII code.
- wr_dp  input  1  decimal point for that character.
- scroll_en  input  1  enables scrolling.
- Segments  output  7  {g,f,e,d,c,b,a}, registered.
- dp  output  1  decimal point, registered.
- Digit_sel  output  DIGITS  digit enables; bit 0 is the leftmost digit. Registered.
- frame_pulse  output  1  one-clock pulse at the end of each full frame.

## Operation
- Buffer: MSG_LEN entries of {dp, char[7:0]}. Reset fills every entry with {0, 8'h20}.
- Write: wr_en=1 with wr_addr < MSG_LEN updates the entry on that edge. wr_addr ≥ MSG_LEN is ignored.
- Digit i shows buf[(offset + i) mod MSG_LEN].
- Decode is case-insensitive for letters. All values below are active-high.
  - Digits '0'..'9': 3F 06 5B 4F 66 6D 7D 07 7F 6F.
  - Letters A..Z: 77 7C 39 5E 79 71 3D 76 06 1E 75 38 37 54 5C 73 67 50 6D 78 3E 1C 2A 64 6E 5B.
  - '-' = 40, '_' = 08, ' ' = 00.
  - Any other code = 49 (unknown glyph).
- FSM states: BLANK and ON.
  - BLANK: all selects off, Segments off, dp off. Lasts BLANK_CYCLES clocks, then goes to ON.
  - ON: Digit_sel one-hot at idx, with the decoded Segments and dp of that digit. Lasts TICK_DIV − BLANK_CYCLES clocks, then goes to BLANK and idx advances.
  - idx wraps DIGITS−1 → 0. frame_pulse is asserted on the ON→BLANK edge of idx = DIGITS−1.
- Scroll:
  - A frame counter counts frame_pulse while scroll_en=1.
  - On reaching SCROLL_FRAMES, offset increments mod MSG_LEN and the counter clears.
  - scroll_en=0 holds both offset and the counter, and does not reset them.
- COMMON_ANODE=1 inverts Segments, dp and Digit_sel at the output registers only.

## Timing
- Reset values, asynchronous:
  - State BLANK, idx 0, offset 0, all counters 0, frame_pulse 0.
  - Segments, dp and Digit_sel at the inactive level: 0 for common cathode, all-ones for common anode.
- After reset release, the first ON slot (digit 0) begins BLANK_CYCLES clocks after the first active edge.
- Character data, offset and glyph are sampled on the BLANK→ON edge and held for the whole ON period.
- A write that lands during ON is shown at that digit's next slot.
- A write to the entry being sampled on the same edge as BLANK→ON shows the old value in that slot.
- An offset increment takes effect from the next frame only. The increment happens on the frame_pulse edge, so all digits of a frame use one offset.
- Reset asserted mid-slot forces outputs inactive immediately, without waiting for a clock edge.
- Full frame period = DIGITS × TICK_DIV clocks.
- Segments never change while any Digit_sel is active, except on the ON→BLANK edge.

## Test plan
- Reset and idle: bench parameters TICK_DIV=20, BLANK_CYCLES=4.
  - Required: Segments=00, Digit_sel=0 during reset.
  - Required: after release, digit 0 is active with Segments=00 for 16 clocks, with 4 blank clocks between slots.
- Write and decode: write "12Ab" at addresses 0..3 with wr_dp=1 on address 1.
  - Required: per slot, Digit_sel 0001/0010/0100/1000 with Segments 06, 5B (dp=1), 77, 7C.
  - Required: 'b' and 'B' both give 7C.
- Unknown and out-of-range: write 8'h2A at address 2.
  - Required: digit 2 shows 49.
  - Required: a write at wr_addr=MSG_LEN leaves every digit unchanged.
- Scroll wrap: bench parameters MSG_LEN=6, SCROLL_FRAMES=2, buffer "HELLO ", scroll_en=1.
  - Required: offset steps every 2 frame_pulses.
  - Required: after 5 steps the digits show " HEL" (00 76 79 38).
  - Required: clearing scroll_en freezes the display.
- Common anode: COMMON_ANODE=1 with buffer "8".
  - Required: during digit 0's ON slot, Segments=00 (inverted 7F) and Digit_sel=1110.
  - Required: all-ones outputs during BLANK and reset.
- Reset mid-operation: assert rst_n=0 in the middle of an ON slot.
  - Required: outputs go inactive before the next edge.
  - Required: the buffer returns to spaces and offset to 0.

Source files
------------

// File: rtl/ascii_mux_display_if.sv
// Character write bus and scroll control for the multiplexed ASCII display.
interface ascii_mux_display_if #(
  parameter int MSG_LEN = 16
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          wr_dp;
  logic          scroll_en;

  modport master (output wr_en, wr_addr, wr_data, wr_dp, scroll_en);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp, scroll_en);
endinterface

// File: rtl/ascii_mux_display.sv
// Time-multiplexed multi-digit 7-segment driver with ASCII decode,
// a writable message buffer and frame-based horizontal scrolling.
module ascii_mux_display #(
  parameter int DIGITS        = 4,
  parameter int MSG_LEN       = 16,
  parameter int TICK_DIV      = 12500,
  parameter int BLANK_CYCLES  = 50,
  parameter int SCROLL_FRAMES = 250,
  parameter bit COMMON_ANODE  = 1'b0
) (
  input  logic               clk50MHz,
  input  logic               rst_n,
  ascii_mux_display_if.slave bus,
  output logic [6:0]         Segments,
  output logic               dp,
  output logic [DIGITS-1:0]  Digit_sel,
  output logic               frame_pulse
);
  localparam int AW     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW     = $clog2(TICK_DIV);
  localparam int FW     = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam int ON_LEN = TICK_DIV - BLANK_CYCLES;

  localparam logic [AW:0]       LEN_V   = (AW+1)'(MSG_LEN);
  localparam logic [6:0]        SEG_INV = {7{COMMON_ANODE}};
  localparam logic              DP_INV  = COMMON_ANODE;
  localparam logic [DIGITS-1:0] SEL_INV = {DIGITS{COMMON_ANODE}};

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  function automatic logic [6:0] glyph(input logic [7:0] c);
    logic [7:0] u;
    logic [6:0] g;
    u = (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    case (u)
      8'h30: g = 7'h3F;  8'h31: g = 7'h06;  8'h32: g = 7'h5B;  8'h33: g = 7'h4F;
      8'h34: g = 7'h66;  8'h35: g = 7'h6D;  8'h36: g = 7'h7D;  8'h37: g = 7'h07;
      8'h38: g = 7'h7F;  8'h39: g = 7'h6F;
      8'h41: g = 7'h77;  8'h42: g = 7'h7C;  8'h43: g = 7'h39;  8'h44: g = 7'h5E;
      8'h45: g = 7'h79;  8'h46: g = 7'h71;  8'h47: g = 7'h3D;  8'h48: g = 7'h76;
      8'h49: g = 7'h06;  8'h4A: g = 7'h1E;  8'h4B: g = 7'h75;  8'h4C: g = 7'h38;
      8'h4D: g = 7'h37;  8'h4E: g = 7'h54;  8'h4F: g = 7'h5C;  8'h50: g = 7'h73;
      8'h51: g = 7'h67;  8'h52: g = 7'h50;  8'h53: g = 7'h6D;  8'h54: g = 7'h78;
      8'h55: g = 7'h3E;  8'h56: g = 7'h1C;  8'h57: g = 7'h2A;  8'h58: g = 7'h64;
      8'h59: g = 7'h6E;  8'h5A: g = 7'h5B;
      8'h2D: g = 7'h40;  8'h5F: g = 7'h08;  8'h20: g = 7'h00;
      default: g = 7'h49;
    endcase
    return g;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   idx_q;
  logic [AW-1:0]   offset_q;
  logic [FW-1:0]   frm_q;
  logic            started_q;
  logic [7:0]      char_q [MSG_LEN];
  logic            dpb_q  [MSG_LEN];

  logic            go_on, go_blank, frame_end;
  logic [AW:0]     sum;
  logic [AW-1:0]   sel_addr;
  logic [6:0]      seg_glyph;
  logic            dp_glyph;
  logic [DIGITS-1:0] onehot;

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) state_q <= ST_BLANK;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    go_on     = 1'b0;
    go_blank  = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      ST_BLANK: if (started_q && cnt_q == CW'(BLANK_CYCLES - 1)) begin
        state_d = ST_ON;
        go_on   = 1'b1;
      end
      ST_ON: if (cnt_q == CW'(ON_LEN - 1)) begin
        state_d   = ST_BLANK;
        go_blank  = 1'b1;
        frame_end = (idx_q == IW'(DIGITS - 1));
      end
      default: state_d = ST_BLANK;
    endcase
  end

  // Character fetch for the digit about to be lit: buf[(offset + idx) mod MSG_LEN]
  always_comb begin
    sum       = {1'b0, offset_q} + (AW+1)'(idx_q);
    sel_addr  = (sum >= LEN_V) ? AW'(sum - LEN_V) : AW'(sum);
    seg_glyph = glyph(char_q[sel_addr]);
    dp_glyph  = dpb_q[sel_addr];
    onehot    = DIGITS'(1) << idx_q;
  end

  // The first edge after reset release acts as the slot entry edge, so the
  // first ON slot starts BLANK_CYCLES clocks after it.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      started_q   <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      frame_pulse <= 1'b0;
      Segments    <= SEG_INV;
      dp          <= DP_INV;
      Digit_sel   <= SEL_INV;
    end else begin
      started_q   <= 1'b1;
      frame_pulse <= frame_end;
      if (go_on || go_blank) cnt_q <= '0;
      else if (started_q)    cnt_q <= cnt_q + 1'b1;
      if (go_blank) idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (go_on) begin
        Segments  <= seg_glyph ^ SEG_INV;
        dp        <= dp_glyph ^ DP_INV;
        Digit_sel <= onehot ^ SEL_INV;
      end else if (go_blank) begin
        Segments  <= SEG_INV;
        dp        <= DP_INV;
        Digit_sel <= SEL_INV;
      end
    end
  end

  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        char_q[i] <= 8'h20;
        dpb_q[i]  <= 1'b0;
      end
    end else if (bus.wr_en && ({1'b0, bus.wr_addr} < LEN_V)) begin
      char_q[bus.wr_addr] <= bus.wr_data;
      dpb_q[bus.wr_addr]  <= bus.wr_dp;
    end
  end

  // Offset moves on the frame-end edge, so every digit of a frame shares one offset.
  always_ff @(posedge clk50MHz or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      frm_q    <= '0;
    end else if (frame_end && bus.scroll_en) begin
      if (frm_q == FW'(SCROLL_FRAMES - 1)) begin
        frm_q    <= '0;
        offset_q <= (offset_q == AW'(MSG_LEN - 1)) ? '0 : offset_q + 1'b1;
      end else begin
        frm_q <= frm_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ascii_mux_display.sv
// Directed bench for ascii_mux_display: a common-cathode and a common-anode
// instance share one write bus, clock and reset.
module tb_ascii_mux_display;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  logic [6:0] seg_cc, seg_ca;
  logic [3:0] sel_cc, sel_ca;
  logic       dp_cc, dp_ca, fp_cc, fp_ca;

  ascii_mux_display_if #(.MSG_LEN(6)) bus ();

  ascii_mux_display #(
    .DIGITS(4), .MSG_LEN(6), .TICK_DIV(20), .BLANK_CYCLES(4),
    .SCROLL_FRAMES(2), .COMMON_ANODE(1'b0)
  ) dut (
    .clk50MHz(clk), .rst_n(rst_n), .bus(bus),
    .Segments(seg_cc), .dp(dp_cc), .Digit_sel(sel_cc), .frame_pulse(fp_cc)
  );

  ascii_mux_display #(
    .DIGITS(4), .MSG_LEN(6), .TICK_DIV(20), .BLANK_CYCLES(4),
    .SCROLL_FRAMES(2), .COMMON_ANODE(1'b1)
  ) dut_ca (
    .clk50MHz(clk), .rst_n(rst_n), .bus(bus),
    .Segments(seg_ca), .dp(dp_ca), .Digit_sel(sel_ca), .frame_pulse(fp_ca)
  );

  always #5 clk = ~clk;

  task automatic write_char(input logic [2:0] a, input logic [7:0] d, input logic p);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d; bus.wr_dp = p;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Returns #1 after the edge on which frame_pulse is seen high.
  task automatic wait_frame();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(posedge clk); #1;
      if (fp_cc === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      tests_run++; tests_failed++;
      $display("FAIL wait_frame: frame_pulse not seen within 200 cycles");
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_sel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({sel_cc, seg_cc, dp_cc, fp_cc} !== {4'b0000, 7'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_cc: got sel=%b seg=%h dp=%b fp=%b, want 0000/00/0/0", sel_cc, seg_cc, dp_cc, fp_cc);
    end
    tests_run++;
    if ({sel_ca, seg_ca, dp_ca, fp_ca} !== {4'b1111, 7'h7F, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_ca: got sel=%b seg=%h dp=%b fp=%b, want 1111/7f/1/0", sel_ca, seg_ca, dp_ca, fp_ca);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(posedge clk); #1;
      exp_sel = (e >= 5 && e <= 20) ? 4'b0001 : (e == 25) ? 4'b0010 : 4'b0000;
      tests_run++;
      if ({sel_cc, seg_cc} !== {exp_sel, 7'h00}) begin
        tests_failed++;
        $display("FAIL idle_edge%0d: got sel=%b seg=%h, want sel=%b seg=00", e, sel_cc, seg_cc, exp_sel);
      end
    end
  endtask

  task automatic test_write_decode();
    logic [6:0] exp_seg [4] = '{7'h06, 7'h5B, 7'h77, 7'h7C};
    logic       exp_dp  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    write_char(3'd0, 8'h31, 1'b0);
    write_char(3'd1, 8'h32, 1'b1);
    write_char(3'd2, 8'h41, 1'b0);
    write_char(3'd3, 8'h62, 1'b0);
    wait_frame();
    repeat (4) @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (20) @(posedge clk);
      #1;
      tests_run++;
      if ({sel_cc, seg_cc, dp_cc} !== {4'(1 << d), exp_seg[d], exp_dp[d]}) begin
        tests_failed++;
        $display("FAIL decode_digit%0d: got sel=%b seg=%h dp=%b, want sel=%b seg=%h dp=%b",
                 d, sel_cc, seg_cc, dp_cc, 4'(1 << d), exp_seg[d], exp_dp[d]);
      end
      #0;
    end
    write_char(3'd3, 8'h42, 1'b0);
    wait_frame();
    repeat (64) @(posedge clk); #1;
    tests_run++;
    if ({sel_cc, seg_cc} !== {4'b1000, 7'h7C}) begin
      tests_failed++;
      $display("FAIL upper_B: got sel=%b seg=%h, want sel=1000 seg=7c", sel_cc, seg_cc);
    end
  endtask

  task automatic test_unknown_range();
    logic [6:0] exp_seg [4] = '{7'h06, 7'h5B, 7'h49, 7'h7C};
    write_char(3'd2, 8'h2A, 1'b0);
    write_char(3'd6, 8'h38, 1'b1);
    write_char(3'd7, 8'h38, 1'b1);
    wait_frame();
    repeat (4) @(posedge clk);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (20) @(posedge clk);
      #1;
      tests_run++;
      if ({sel_cc, seg_cc} !== {4'(1 << d), exp_seg[d]}) begin
        tests_failed++;
        $display("FAIL unknown_digit%0d: got sel=%b seg=%h, want sel=%b seg=%h",
                 d, sel_cc, seg_cc, 4'(1 << d), exp_seg[d]);
      end
    end
  endtask

  task automatic test_scroll();
    logic [7:0] msg [6]  = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h20};
    logic [6:0] exp0 [10] = '{7'h76, 7'h79, 7'h79, 7'h38, 7'h38, 7'h38, 7'h38, 7'h5C, 7'h5C, 7'h00};
    logic [6:0] last [4]  = '{7'h00, 7'h76, 7'h79, 7'h38};
    for (int i = 0; i < 6; i++) write_char(3'(i), msg[i], 1'b0);
    wait_frame();
    bus.scroll_en = 1'b1;
    for (int p = 0; p < 10; p++) begin
      wait_frame();
      repeat (4) @(posedge clk); #1;
      tests_run++;
      if ({sel_cc, seg_cc} !== {4'b0001, exp0[p]}) begin
        tests_failed++;
        $display("FAIL scroll_pulse%0d: got sel=%b seg=%h, want sel=0001 seg=%h", p + 1, sel_cc, seg_cc, exp0[p]);
      end
    end
    for (int d = 1; d < 4; d++) begin
      repeat (20) @(posedge clk); #1;
      tests_run++;
      if ({sel_cc, seg_cc} !== {4'(1 << d), last[d]}) begin
        tests_failed++;
        $display("FAIL scroll_final_digit%0d: got sel=%b seg=%h, want sel=%b seg=%h",
                 d, sel_cc, seg_cc, 4'(1 << d), last[d]);
      end
    end
    bus.scroll_en = 1'b0;
    for (int f = 0; f < 3; f++) begin
      wait_frame();
      repeat (4) @(posedge clk); #1;
      tests_run++;
      if ({sel_cc, seg_cc} !== {4'b0001, 7'h00}) begin
        tests_failed++;
        $display("FAIL freeze%0d_digit0: got sel=%b seg=%h, want sel=0001 seg=00", f, sel_cc, seg_cc);
      end
      repeat (20) @(posedge clk); #1;
      tests_run++;
      if ({sel_cc, seg_cc} !== {4'b0010, 7'h76}) begin
        tests_failed++;
        $display("FAIL freeze%0d_digit1: got sel=%b seg=%h, want sel=0010 seg=76", f, sel_cc, seg_cc);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (6) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    tests_run++;
    if ({sel_cc, seg_cc, dp_cc, fp_cc} !== {4'b0000, 7'h00, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL midreset_cc: got sel=%b seg=%h dp=%b fp=%b, want 0000/00/0/0", sel_cc, seg_cc, dp_cc, fp_cc);
    end
    tests_run++;
    if ({sel_ca, seg_ca, dp_ca} !== {4'b1111, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL midreset_ca: got sel=%b seg=%h dp=%b, want 1111/7f/1", sel_ca, seg_ca, dp_ca);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    write_char(3'd0, 8'h31, 1'b0);
    repeat (3) @(posedge clk); #1;
    tests_run++;
    if ({sel_cc, seg_cc} !== {4'b0001, 7'h06}) begin
      tests_failed++;
      $display("FAIL offset_cleared: got sel=%b seg=%h, want sel=0001 seg=06", sel_cc, seg_cc);
    end
    for (int d = 1; d < 3; d++) begin
      repeat (20) @(posedge clk); #1;
      tests_run++;
      if ({sel_cc, seg_cc} !== {4'(1 << d), 7'h00}) begin
        tests_failed++;
        $display("FAIL buffer_cleared_digit%0d: got sel=%b seg=%h, want sel=%b seg=00", d, sel_cc, seg_cc, 4'(1 << d));
      end
    end
  endtask

  task automatic test_common_anode();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if ({sel_ca, seg_ca, dp_ca} !== {4'b1111, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL ca_reset: got sel=%b seg=%h dp=%b, want 1111/7f/1", sel_ca, seg_ca, dp_ca);
    end
    @(negedge clk); rst_n = 1'b1;
    write_char(3'd0, 8'h38, 1'b0);
    @(posedge clk); #1;
    tests_run++;
    if ({sel_ca, seg_ca, dp_ca} !== {4'b1111, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("FAIL ca_blank: got sel=%b seg=%h dp=%b, want 1111/7f/1", sel_ca, seg_ca, dp_ca);
    end
    repeat (2) @(posedge clk); #1;
    tests_run++;
    if ({sel_ca, seg_ca, dp_ca} !== {4'b1110, 7'h00, 1'b1}) begin
      tests_failed++;
      $display("FAIL ca_on: got sel=%b seg=%h dp=%b, want 1110/00/1", sel_ca, seg_ca, dp_ca);
    end
    tests_run++;
    if ({sel_cc, seg_cc, dp_cc} !== {4'b0001, 7'h7F, 1'b0}) begin
      tests_failed++;
      $display("FAIL cc_eight: got sel=%b seg=%h dp=%b, want 0001/7f/0", sel_cc, seg_cc, dp_cc);
    end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = 8'h00; bus.wr_dp = 1'b0;
    bus.scroll_en = 1'b0;
    test_reset();
    test_write_decode();
    test_unknown_range();
    test_scroll();
    test_reset_mid();
    test_common_anode();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
